// File: rtl/order_dispatcher_if.sv
// Parser-side order inputs and book-side issue outputs of the order dispatcher.
// The stats counters exist only when DISPATCH_STATS_EN is defined.
interface order_dispatcher_if #(
    parameter int REG_WIDTH  = 32,
    parameter int FIFO_DEPTH = 8
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                 i_valid;
    logic [1:0]           i_stock_symbol;
    logic [REG_WIDTH-1:0] i_order_id;
    logic [REG_WIDTH-1:0] i_price;
    logic [REG_WIDTH-1:0] i_quantity;
    logic [1:0]           i_order_type;
    logic                 i_trade_type;
    logic [3:0]           i_book_busy;

    logic [3:0]           o_book_valid;
    logic [REG_WIDTH-1:0] o_order_id;
    logic [REG_WIDTH-1:0] o_price;
    logic [REG_WIDTH-1:0] o_quantity;
    logic [1:0]           o_order_type;
    logic                 o_trade_type;
    logic [LW-1:0]        o_fifo_level;
    logic                 o_fifo_full;
    logic                 o_fifo_empty;
    logic                 o_drop;
`ifdef DISPATCH_STATS_EN
    logic [31:0]          o_issue_count;
    logic [31:0]          o_drop_count;
`endif

    modport slave (
        input  i_valid, i_stock_symbol, i_order_id, i_price, i_quantity,
               i_order_type, i_trade_type, i_book_busy,
        output o_book_valid, o_order_id, o_price, o_quantity, o_order_type,
               o_trade_type, o_fifo_level, o_fifo_full, o_fifo_empty, o_drop
`ifdef DISPATCH_STATS_EN
        , output o_issue_count, o_drop_count
`endif
    );

    modport master (
        output i_valid, i_stock_symbol, i_order_id, i_price, i_quantity,
               i_order_type, i_trade_type, i_book_busy,
        input  o_book_valid, o_order_id, o_price, o_quantity, o_order_type,
               o_trade_type, o_fifo_level, o_fifo_full, o_fifo_empty, o_drop
`ifdef DISPATCH_STATS_EN
        , input o_issue_count, o_drop_count
`endif
    );
endinterface

// File: rtl/order_dispatcher.sv
// In-order FIFO dispatcher from the parser to four per-stock books, honouring book busy.
// Optional issue/drop counters are enabled by DISPATCH_STATS_EN.
module order_dispatcher #(
    parameter int REG_WIDTH  = 32,
    parameter int FIFO_DEPTH = 8
) (
    input logic               i_clk,
    input logic               i_rst,
    order_dispatcher_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [1:0]           sym;
        logic [REG_WIDTH-1:0] id;
        logic [REG_WIDTH-1:0] price;
        logic [REG_WIDTH-1:0] qty;
        logic [1:0]           otype;
        logic                 trade;
    } entry_t;

    typedef enum logic {IDLE, GUARD} state_t;

    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_q, level_d;
    logic          full, empty;
    logic          full_q, empty_q;
    logic          push, pop, drop;
    state_t        state_q, state_d;

    assign head  = mem[rd_ptr];
    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign empty = (level_q == '0);

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push = bus.i_valid && (!full || pop);
    assign drop = bus.i_valid && full && !pop;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty && !bus.i_book_busy[head.sym]) begin
                pop     = 1'b1;
                state_d = GUARD;
            end
            GUARD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            full_q  <= (level_d == LW'(FIFO_DEPTH));
            empty_q <= (level_d == '0);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= '{sym: bus.i_stock_symbol, id: bus.i_order_id,
                             price: bus.i_price, qty: bus.i_quantity,
                             otype: bus.i_order_type, trade: bus.i_trade_type};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_book_valid <= '0;
            bus.o_order_id   <= '0;
            bus.o_price      <= '0;
            bus.o_quantity   <= '0;
            bus.o_order_type <= '0;
            bus.o_trade_type <= 1'b0;
            bus.o_drop       <= 1'b0;
        end else begin
            bus.o_drop       <= drop;
            bus.o_book_valid <= '0;
            if (pop) begin
                bus.o_book_valid[head.sym] <= 1'b1;
                bus.o_order_id             <= head.id;
                bus.o_price                <= head.price;
                bus.o_quantity             <= head.qty;
                bus.o_order_type           <= head.otype;
                bus.o_trade_type           <= head.trade;
            end
        end
    end

    assign bus.o_fifo_level = level_q;
    assign bus.o_fifo_full  = full_q;
    assign bus.o_fifo_empty = empty_q;

`ifdef DISPATCH_STATS_EN
    logic [31:0] issue_cnt, drop_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            issue_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (pop)  issue_cnt <= issue_cnt + 32'd1;
            if (drop) drop_cnt  <= drop_cnt + 32'd1;
        end
    end

    assign bus.o_issue_count = issue_cnt;
    assign bus.o_drop_count  = drop_cnt;
`endif
endmodule
